// File: rtl/v60_pkg.sv
// Shared definitions for the V60 instruction prefetch unit: default geometry,
// reset fetch address and the fetch FSM state encoding.
`ifndef V60_ADDR_WIDTH
`define V60_ADDR_WIDTH 32
`endif
`ifndef V60_DATA_WIDTH
`define V60_DATA_WIDTH 32
`endif

package v60_pkg;

   localparam int unsigned V60_QUEUE_BYTES = 16;
   localparam int unsigned V60_WIN_BYTES   = 8;
   localparam logic [`V60_ADDR_WIDTH-1:0] V60_RESET_PC = 32'h0000_0000;
   localparam logic [1:0] V60_MEM_SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DISCARD,
      S_FAULT
   } pf_state_e;

endpackage

// File: rtl/v60_byte_queue.sv
// Circular byte queue for the prefetcher: pushes up to one word per cycle,
// pops a variable number of bytes and exposes the oldest WIN_BYTES as a window.
`ifndef V60_ADDR_WIDTH
`define V60_ADDR_WIDTH 32
`endif
`ifndef V60_DATA_WIDTH
`define V60_DATA_WIDTH 32
`endif

module v60_byte_queue
   import v60_pkg::*;
#(
   parameter int unsigned QUEUE_BYTES = V60_QUEUE_BYTES,
   parameter int unsigned WIN_BYTES   = V60_WIN_BYTES
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clear,
   input  logic [2:0]                         push_len,
   input  logic [`V60_DATA_WIDTH-1:0]         push_data,
   input  logic [3:0]                         pop_len,
   output logic [WIN_BYTES*8-1:0]             win_data,
   output logic [$clog2(QUEUE_BYTES+1)-1:0]   occupancy
);

   localparam int unsigned PW = $clog2(QUEUE_BYTES);
   localparam int unsigned OW = $clog2(QUEUE_BYTES+1);

   logic [7:0]    mem_q [QUEUE_BYTES];
   logic [PW-1:0] head_q;
   logic [OW-1:0] occ_q;
   logic [PW-1:0] tail;

   // A full queue has tail == head; the truncated occupancy gives exactly that.
   assign tail      = head_q + occ_q[PW-1:0];
   assign occupancy = occ_q;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!clear && (3'(i) < push_len)) begin
            mem_q[tail + PW'(i)] <= push_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         occ_q  <= '0;
      end else if (clear) begin
         head_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_q + PW'(pop_len);
         occ_q  <= occ_q + OW'(push_len) - OW'(pop_len);
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < WIN_BYTES; i++) begin
         win_data[8*i +: 8] = mem_q[head_q + PW'(i)];
      end
   end

endmodule

// File: rtl/v60_prefetch.sv
// V60 instruction prefetcher: word fetch FSM with flush redirect and fault
// capture, feeding a byte queue that presents a decode window to the consumer.
//
// state     | meaning
// S_IDLE    | no request; waiting for at least one word of free queue space
// S_REQ     | word read outstanding at mem_addr; data is pushed on ready
// S_DISCARD | stale read outstanding after a flush; data dropped on ready
// S_FAULT   | bus fault seen; no requests until the next flush
`ifndef V60_ADDR_WIDTH
`define V60_ADDR_WIDTH 32
`endif
`ifndef V60_DATA_WIDTH
`define V60_DATA_WIDTH 32
`endif

module v60_prefetch
   import v60_pkg::*;
#(
   parameter int unsigned QUEUE_BYTES = V60_QUEUE_BYTES,
   parameter int unsigned WIN_BYTES   = V60_WIN_BYTES,
   parameter logic [`V60_ADDR_WIDTH-1:0] RESET_PC = V60_RESET_PC
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   input  logic [`V60_ADDR_WIDTH-1:0]       flush_pc,
   output logic                             mem_req,
   output logic [`V60_ADDR_WIDTH-1:0]       mem_addr,
   output logic [1:0]                       mem_size,
   input  logic [`V60_DATA_WIDTH-1:0]       mem_rdata,
   input  logic                             mem_ready,
   input  logic                             mem_err,
   output logic [WIN_BYTES*8-1:0]           win_data,
   output logic [$clog2(WIN_BYTES+1)-1:0]   win_count,
   output logic [`V60_ADDR_WIDTH-1:0]       win_pc,
   input  logic                             consume,
   input  logic [3:0]                       consume_len,
   output logic                             consume_err,
   output logic                             fault,
   output logic [`V60_ADDR_WIDTH-1:0]       fault_pc
);

   localparam int unsigned AW = `V60_ADDR_WIDTH;
   localparam int unsigned OW = $clog2(QUEUE_BYTES+1);
   localparam int unsigned CW = $clog2(WIN_BYTES+1);
   localparam logic [OW:0] ROOM_LIMIT = (OW+1)'(QUEUE_BYTES - 4);

   pf_state_e     state_q, state_d;
   logic [AW-1:0] mem_addr_q, next_addr_q, win_pc_q, fault_pc_q;
   logic [1:0]    skip_q;
   logic          first_q, fault_q, consume_err_q;

   logic [OW-1:0] occupancy;
   logic [1:0]    skip_eff;
   logic [2:0]    word_len;
   logic [2:0]    push_len;
   logic [3:0]    pop_len;
   logic [`V60_DATA_WIDTH-1:0] push_data;
   logic          room_now, room_after;
   logic          pop_ok, reject;
   logic [AW-1:0] flush_word;

   assign flush_word = {flush_pc[AW-1:2], 2'b00};
   assign skip_eff   = first_q ? skip_q : 2'b00;
   assign word_len   = 3'd4 - {1'b0, skip_eff};
   assign push_data  = mem_rdata >> {skip_eff, 3'b000};

   // Space checks use the registered occupancy, which already reflects last
   // cycle's pop; same-cycle pops only ever add room, so overflow cannot occur.
   assign room_now   = {1'b0, occupancy} <= ROOM_LIMIT;
   assign room_after = ({1'b0, occupancy} + {{(OW-2){1'b0}}, word_len}) <= ROOM_LIMIT;

   assign win_count = (occupancy > OW'(WIN_BYTES)) ? CW'(WIN_BYTES) : CW'(occupancy);

   assign pop_ok  = consume && !flush && (consume_len != 4'd0)
                    && ({4'b0000, consume_len} <= 8'(win_count));
   assign reject  = consume && !flush && !pop_ok;
   assign pop_len = pop_ok ? consume_len : 4'd0;

   always_comb begin
      state_d  = state_q;
      push_len = 3'd0;
      unique case (state_q)
         S_IDLE: begin
            if (flush || room_now) state_d = S_REQ;
         end
         S_REQ: begin
            if (flush) begin
               state_d = mem_ready ? S_REQ : S_DISCARD;
            end else if (mem_ready) begin
               if (mem_err) begin
                  state_d = S_FAULT;
               end else begin
                  push_len = word_len;
                  state_d  = room_after ? S_REQ : S_IDLE;
               end
            end
         end
         S_DISCARD: begin
            if (mem_ready) state_d = S_REQ;
         end
         S_FAULT: begin
            if (flush) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         mem_addr_q    <= {RESET_PC[AW-1:2], 2'b00};
         next_addr_q   <= '0;
         skip_q        <= RESET_PC[1:0];
         first_q       <= 1'b1;
         win_pc_q      <= RESET_PC;
         fault_q       <= 1'b0;
         fault_pc_q    <= '0;
         consume_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         consume_err_q <= reject;
         if (flush) begin
            // An unfinished request must keep its address until ready, so the
            // redirect target waits in next_addr_q.
            if ((state_q == S_REQ || state_q == S_DISCARD) && !mem_ready) begin
               next_addr_q <= flush_word;
            end else begin
               mem_addr_q <= flush_word;
            end
            skip_q   <= flush_pc[1:0];
            first_q  <= 1'b1;
            win_pc_q <= flush_pc;
            fault_q  <= 1'b0;
         end else begin
            if (state_q == S_REQ && mem_ready) begin
               if (mem_err) begin
                  fault_q    <= 1'b1;
                  fault_pc_q <= mem_addr_q;
               end else begin
                  mem_addr_q <= mem_addr_q + AW'(4);
                  first_q    <= 1'b0;
               end
            end
            if (state_q == S_DISCARD && mem_ready) begin
               mem_addr_q <= next_addr_q;
            end
            if (pop_ok) begin
               win_pc_q <= win_pc_q + AW'(consume_len);
            end
         end
      end
   end

   v60_byte_queue #(
      .QUEUE_BYTES (QUEUE_BYTES),
      .WIN_BYTES   (WIN_BYTES)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .push_len  (push_len),
      .push_data (push_data),
      .pop_len   (pop_len),
      .win_data  (win_data),
      .occupancy (occupancy)
   );

   assign mem_req     = (state_q == S_REQ) || (state_q == S_DISCARD);
   assign mem_addr    = mem_addr_q;
   assign mem_size    = V60_MEM_SIZE_WORD;
   assign win_pc      = win_pc_q;
   assign consume_err = consume_err_q;
   assign fault       = fault_q;
   assign fault_pc    = fault_pc_q;

endmodule
